fixed_point_accumulator: RTL and testbench

Sequential sign-magnitude fixed-point accumulator that sums a packet of Q_M.Q_N operands streamed over a valid/ready handshake. Packet end is marked by in_last. It is the perceptron's dot-product reduction stage, fed by the weight-times-input multiplier. It adds width parametrisation, guard bits, handshaking, overflow reporting and negative-zero normalisation.

---
 rtl/fxp_pkg.sv | 16 +
 rtl/sm_adder_core.sv | 38 +++
 rtl/fixed_point_accumulator.sv | 116 +++++++++++
 tb/tb_fixed_point_accumulator.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Shared types and helpers for the fixed-point accumulator: FSM state encoding
// and the zero-sign normalisation used wherever a sign-magnitude result is formed.
package fxp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A zero magnitude always carries a positive sign, so -0 never escapes.
  function automatic logic norm_sign(input logic sign, input logic mag_is_zero);
    return sign & ~mag_is_zero;
  endfunction

endpackage

// File: rtl/sm_adder_core.sv
// Combinational sign-magnitude adder. carry_out flags a magnitude that did not
// fit in WIDTH bits (same-sign addition only); the sign is kept in that case.
module sm_adder_core
  import fxp_pkg::*;
#(
  parameter int WIDTH = 35
) (
  input  logic             a_sign,
  input  logic [WIDTH-1:0] a_mag,
  input  logic             b_sign,
  input  logic [WIDTH-1:0] b_mag,
  output logic             sum_sign,
  output logic [WIDTH-1:0] sum_mag,
  output logic             carry_out
);

  logic [WIDTH:0] mag_sum;
  logic           raw_sign;

  always_comb begin
    mag_sum   = {1'b0, a_mag} + {1'b0, b_mag};
    carry_out = 1'b0;
    raw_sign  = a_sign;
    sum_mag   = '0;
    if (a_sign == b_sign) begin
      sum_mag   = mag_sum[WIDTH-1:0];
      carry_out = mag_sum[WIDTH];
    end else if (a_mag >= b_mag) begin
      sum_mag  = a_mag - b_mag;
    end else begin
      sum_mag  = b_mag - a_mag;
      raw_sign = b_sign;
    end
    // A wrapped carry result may be zero yet still needs its sign for clamping.
    sum_sign = norm_sign(raw_sign, (sum_mag == '0) && !carry_out);
  end

endmodule

// File: rtl/fixed_point_accumulator.sv
// Packet accumulator for sign-magnitude Q_M.Q_N operands with guard bits and
// overflow reporting. Define FXP_ACC_SATURATE_EN to clamp instead of wrapping.
module fixed_point_accumulator
  import fxp_pkg::*;
#(
  parameter int Q_M        = 16,
  parameter int Q_N        = 15,
  parameter int GUARD_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [Q_M+Q_N:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Q_M+Q_N:0]     out_data,
  output logic                 out_overflow,
  output logic                 busy
);

  localparam int W  = 1 + Q_M + Q_N;
  localparam int QW = Q_M + Q_N;
  localparam int MW = QW + GUARD_BITS;
  localparam logic [MW-1:0] Q_MAX = MW'({QW{1'b1}});

  state_t          state;
  logic            acc_sign;
  logic [MW-1:0]   acc_mag;
  logic            ovf_sticky;

  logic            b_sign;
  logic [MW-1:0]   b_mag;
  logic            sum_sign;
  logic [MW-1:0]   sum_mag;
  logic            carry;

  logic            next_sign;
  logic [MW-1:0]   next_mag;
  logic            next_ovf;
  logic            narrow_ovf;
  logic [QW-1:0]   narrow_mag;
  logic            accept;

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;

  assign b_mag  = MW'(in_data[QW-1:0]);
  assign b_sign = norm_sign(in_data[W-1], in_data[QW-1:0] == '0);

  // acc is zero whenever the FSM sits in IDLE, so the first beat adds to zero.
  sm_adder_core #(.WIDTH(MW)) u_adder (
    .a_sign    (acc_sign),
    .a_mag     (acc_mag),
    .b_sign    (b_sign),
    .b_mag     (b_mag),
    .sum_sign  (sum_sign),
    .sum_mag   (sum_mag),
    .carry_out (carry)
  );

  always_comb begin
`ifdef FXP_ACC_SATURATE_EN
    next_mag   = carry ? '1 : sum_mag;
    narrow_ovf = (next_mag > Q_MAX);
    narrow_mag = narrow_ovf ? '1 : next_mag[QW-1:0];
`else
    next_mag   = sum_mag;
    narrow_ovf = (next_mag > Q_MAX);
    narrow_mag = next_mag[QW-1:0];
`endif
    next_sign = norm_sign(sum_sign, next_mag == '0);
    next_ovf  = ovf_sticky | carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc_sign     <= 1'b0;
      acc_mag      <= '0;
      ovf_sticky   <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_sign   <= next_sign;
            acc_mag    <= next_mag;
            ovf_sticky <= next_ovf;
            if (in_last) begin
              out_data     <= {norm_sign(next_sign, narrow_mag == '0), narrow_mag};
              out_overflow <= next_ovf | narrow_ovf;
              state        <= DONE;
            end else begin
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state      <= IDLE;
            acc_sign   <= 1'b0;
            acc_mag    <= '0;
            ovf_sticky <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Scoreboard bench for fixed_point_accumulator: a driver pushes expected packet
// results, a negedge monitor pops and compares whenever a result is consumed.
module tb_fixed_point_accumulator;

  localparam int Q_M = 16;
  localparam int Q_N = 15;
  localparam int GB  = 4;
  localparam int W   = 1 + Q_M + Q_N;
  localparam int QW  = Q_M + Q_N;
  localparam int MW  = QW + GB;
  localparam longint LIM_MW = 64'sd1 <<< MW;
  localparam longint LIM_Q  = 64'sd1 <<< QW;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_overflow;
  logic         busy;

  always #5 clk = ~clk;

  fixed_point_accumulator #(.Q_M(Q_M), .Q_N(Q_N), .GUARD_BITS(GB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_overflow (out_overflow),
    .busy         (busy)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         ovf;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] pkt[$];
  int compared   = 0;
  int mismatched = 0;
  int stall_out  = 0;
  bit rdy_random = 1'b0;
  int pkt_no     = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s (pkt %0d): got 0x%08h, required 0x%08h", name, pkt_no, act, req);
    end
  endtask

  // Reference: signed running sum, magnitude wrapped/clamped at 2^MW, then narrowed.
  function automatic exp_t model_pkt();
    longint val = 0;
    longint mag;
    logic [63:0] mag_bits;
    logic ovf = 1'b0;
    exp_t r;
    foreach (pkt[i]) begin
      longint m;
      m = longint'(pkt[i][QW-1:0]);
      val += pkt[i][W-1] ? -m : m;
      mag = (val < 0) ? -val : val;
      if (mag >= LIM_MW) begin
        ovf = 1'b1;
`ifdef FXP_ACC_SATURATE_EN
        mag = LIM_MW - 1;
`else
        mag = mag % LIM_MW;
`endif
        val = (val < 0) ? -mag : mag;
      end
    end
    mag = (val < 0) ? -val : val;
    if (mag >= LIM_Q) begin
      ovf = 1'b1;
`ifdef FXP_ACC_SATURATE_EN
      mag = LIM_Q - 1;
`else
      mag = mag % LIM_Q;
`endif
    end
    mag_bits = mag;
    r.data = {(val < 0) && (mag != 0), mag_bits[QW-1:0]};
    r.ovf  = ovf;
    return r;
  endfunction

  // out_ready driver: forced low while stall_out counts down, else random or high.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_out > 0) begin
        out_ready = 1'b0;
        stall_out--;
      end else begin
        out_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: result checks, DONE stability/backpressure, return to IDLE.
  logic         held = 1'b0;
  logic [W-1:0] held_data;
  logic         held_ovf;
  bit           pend_idle = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      held      = 1'b0;
      pend_idle = 1'b0;
    end else begin
      if (pend_idle) begin
        pend_idle = 1'b0;
        check("idle_after_done", W'({in_ready, out_valid}), W'(2'b10));
      end
      if (out_valid) begin
        check("in_ready_in_done", W'(in_ready), '0);
        if (held) begin
          check("done_data_stable", out_data, held_data);
          check("done_ovf_stable", W'(out_overflow), W'(held_ovf));
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_result: got 0x%08h, required none", out_data);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_overflow", W'(out_overflow), W'(e.ovf));
          end
          held      = 1'b0;
          pend_idle = 1'b1;
        end else begin
          held      = 1'b1;
          held_data = out_data;
          held_ovf  = out_overflow;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, W'(out_valid), '0);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_out_overflow"}, W'(out_overflow), '0);
    check({tag, "_in_ready"}, W'(in_ready), W'(1'b1));
    check({tag, "_busy"}, W'(busy), '0);
  endtask

  // Drives pkt; expectation comes from the model unless one is given.
  task automatic send_packet(input bit use_given, input exp_t given, input bit stall,
                             input bit abort2);
    if (!abort2) exp_q.push_back(use_given ? given : model_pkt());
    foreach (pkt[i]) begin
      int t;
      if (stall) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      in_data  = pkt[i];
      in_last  = (i == pkt.size() - 1);
      in_valid = 1'b1;
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        t++;
        if (t > 50) break;
      end
      if (t > 50) begin
        compared++;
        mismatched++;
        $display("FAIL accept_timeout (pkt %0d): got in_ready=0, required 1", pkt_no);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (abort2 && i == 1) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (i == pkt.size() - 1) check("latency_out_valid", W'(out_valid), W'(1'b1));
    end
    pkt_no++;
  endtask

  initial begin
    exp_t e;
    int t;
    e = '0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1.0 + 2.0 - 0.5 = 2.5
    pkt = '{32'h0000_8000, 32'h0001_0000, 32'h8000_4000};
    send_packet(1'b1, '{32'h0001_4000, 1'b0}, 1'b0, 1'b0);

    pkt = '{32'h0000_C000, 32'h8000_C000};
    send_packet(1'b1, '{32'h0000_0000, 1'b0}, 1'b0, 1'b0);

    pkt = '{32'h8000_0000};
    send_packet(1'b1, '{32'h0000_0000, 1'b0}, 1'b0, 1'b0);

    pkt = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
`ifdef FXP_ACC_SATURATE_EN
    send_packet(1'b1, '{32'h7FFF_FFFF, 1'b1}, 1'b0, 1'b0);
`else
    send_packet(1'b1, '{32'h7FFF_FFFE, 1'b1}, 1'b0, 1'b0);
`endif

    // 17 x max magnitude carries out of the guard bits.
    pkt.delete();
    for (int i = 0; i < 17; i++) pkt.push_back(32'h7FFF_FFFF);
`ifdef FXP_ACC_SATURATE_EN
    send_packet(1'b1, '{32'h7FFF_FFFF, 1'b1}, 1'b0, 1'b0);
`else
    send_packet(1'b1, '{32'h7FFF_FFEF, 1'b1}, 1'b0, 1'b0);
`endif

    // Backpressure: hold out_ready low through DONE, then a back-to-back packet.
    pkt = '{32'h0000_8000, 32'h8001_0000};
    stall_out = 6;
    send_packet(1'b1, '{32'h8000_8000, 1'b0}, 1'b0, 1'b0);
    pkt = '{32'h0000_0001};
    send_packet(1'b1, '{32'h0000_0001, 1'b0}, 1'b0, 1'b0);

    // Same packet with and without input stalls.
    pkt = '{32'h0003_0000, 32'h8000_2000, 32'h0000_0123, 32'h8001_0000};
    send_packet(1'b1, '{32'h0001_E123, 1'b0}, 1'b0, 1'b0);
    send_packet(1'b1, '{32'h0001_E123, 1'b0}, 1'b1, 1'b0);

    // Wait for all outstanding results before the reset abort.
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    pkt = '{32'h0000_8000, 32'h0000_8000, 32'h0000_8000};
    send_packet(1'b0, e, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    pkt = '{32'h0000_8000};
    send_packet(1'b1, '{32'h0000_8000, 1'b0}, 1'b0, 1'b0);

    // Randomised packets with random output backpressure.
    rdy_random = 1'b1;
    for (int p = 0; p < 40; p++) begin
      pkt.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
        logic [W-1:0] v;
        case ($urandom_range(0, 3))
          0: v = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h0001_FFFF))};
          1: v = {1'($urandom_range(0, 1)), 31'($urandom)};
          2: v = {1'($urandom_range(0, 1)), 31'h0};
          default: v = {1'($urandom_range(0, 1)), 31'h7FFF_FFFF - 31'($urandom_range(0, 255))};
        endcase
        pkt.push_back(v);
      end
      send_packet(1'b0, e, 1'($urandom_range(0, 1)), 1'b0);
    end
    rdy_random = 1'b0;

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d results pending, required 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
